// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store path: LDST_* access-size encodings
// (RISC-V funct3 values) and the LSU state type.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// -----------------------------------------------------------------------------
// riscv_lsu_align
// Purely combinational lane logic for the LSU.
//   size_i     : LDST_* access size
//   offset_i   : byte offset within the word (addr[1:0])
//   wd_i       : right-aligned store data
//   rd_word_i  : raw memory read word
//   be_o       : byte enables
//   wd_rep_o   : store data replicated across all lanes
//   rd_ext_o   : selected and sign/zero-extended load data
//   misalign_o : halfword/word access not naturally aligned
//   illegal_o  : size code is not one of the LDST_* encodings
// -----------------------------------------------------------------------------
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_rep_o,
    output logic [31:0] rd_ext_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [7:0]  rd_byte_s;
    logic [15:0] rd_half_s;

    // Pick the addressed byte and halfword out of the read word.
    always_comb begin
        rd_byte_s = rd_word_i[{offset_i, 3'b000} +: 8];
        rd_half_s = rd_word_i[{offset_i[1], 4'b0000} +: 16];
    end

    // Per-size byte enables, store replication, load extension and fault flags.
    always_comb begin
        be_o       = 4'b0000;
        wd_rep_o   = 32'h0000_0000;
        rd_ext_o   = 32'h0000_0000;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        case (size_i)
            LDST_B: begin
                be_o     = 4'b0001 << offset_i;
                wd_rep_o = {4{wd_i[7:0]}};
                rd_ext_o = {{24{rd_byte_s[7]}}, rd_byte_s};
            end
            LDST_BU: begin
                be_o     = 4'b0001 << offset_i;
                wd_rep_o = {4{wd_i[7:0]}};
                rd_ext_o = {24'h00_0000, rd_byte_s};
            end
            LDST_H: begin
                be_o       = 4'b0011 << offset_i;
                wd_rep_o   = {2{wd_i[15:0]}};
                rd_ext_o   = {{16{rd_half_s[15]}}, rd_half_s};
                misalign_o = offset_i[0];
            end
            LDST_HU: begin
                be_o       = 4'b0011 << offset_i;
                wd_rep_o   = {2{wd_i[15:0]}};
                rd_ext_o   = {16'h0000, rd_half_s};
                misalign_o = offset_i[0];
            end
            LDST_W: begin
                be_o       = 4'b1111;
                wd_rep_o   = wd_i;
                rd_ext_o   = rd_word_i;
                misalign_o = (offset_i != 2'b00);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu
// Load/store unit: takes one core access at a time, issues a word-aligned
// memory request, waits (bounded by TIMEOUT_CYCLES) for mem_ready_i, and
// returns extended load data plus a one-cycle fault pulse.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   core_req_i/we/size/addr/wd: core request, held while core_stall_o=1
//   core_rd_o                 : extended load data (holds until next load)
//   core_stall_o              : core must hold its request
//   core_err_o                : fault pulse in the DONE cycle
//   mem_req_o/we/be/addr/wd   : memory request, high throughout BUSY
//   mem_ready_i, mem_rd_i     : memory completion and read word
// -----------------------------------------------------------------------------
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rd_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
    logic [31:0]       core_rd_q, core_rd_d;
    logic              core_err_q, core_err_d;

    logic [2:0]        size_sel_s;
    logic [1:0]        off_sel_s;
    logic [3:0]        be_s;
    logic [31:0]       wd_rep_s;
    logic [31:0]       rd_ext_s;
    logic              misalign_s;
    logic              illegal_s;

    // In IDLE the lane logic decodes the incoming request; afterwards it
    // decodes the captured request so load extension uses the right size.
    always_comb begin
        if (state_q == LSU_IDLE) begin
            size_sel_s = core_size_i;
            off_sel_s  = core_addr_i[1:0];
        end else begin
            size_sel_s = size_q;
            off_sel_s  = off_q;
        end
    end

    riscv_lsu_align u_align (
        .size_i     (size_sel_s),
        .offset_i   (off_sel_s),
        .wd_i       (core_wd_i),
        .rd_word_i  (mem_rd_i),
        .be_o       (be_s),
        .wd_rep_o   (wd_rep_s),
        .rd_ext_o   (rd_ext_s),
        .misalign_o (misalign_s),
        .illegal_o  (illegal_s)
    );

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        off_d      = off_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_be_d   = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        core_rd_d  = core_rd_q;
        core_err_d = core_err_q;
        case (state_q)
            LSU_IDLE: begin
                if (core_req_i) begin
                    we_d   = core_we_i;
                    size_d = core_size_i;
                    off_d  = core_addr_i[1:0];
                    if (misalign_s || illegal_s) begin
                        // Faulting access never reaches memory.
                        state_d    = LSU_DONE;
                        core_err_d = 1'b1;
                        core_rd_d  = 32'h0000_0000;
                    end else begin
                        state_d    = LSU_BUSY;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = core_we_i;
                        mem_be_d   = be_s;
                        mem_addr_d = {core_addr_i[31:2], 2'b00};
                        mem_wd_d   = wd_rep_s;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_BUSY: begin
                if (mem_ready_i || (cnt_q == CNT_LAST)) begin
                    state_d    = LSU_DONE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_be_d   = 4'b0000;
                    mem_addr_d = 32'h0000_0000;
                    mem_wd_d   = 32'h0000_0000;
                    // A ready in the last allowed cycle still completes.
                    if (mem_ready_i) begin
                        if (!we_q) begin
                            core_rd_d = rd_ext_s;
                        end else begin
                            core_rd_d = core_rd_q;
                        end
                    end else begin
                        core_err_d = 1'b1;
                        core_rd_d  = 32'h0000_0000;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_DONE: begin
                state_d    = LSU_IDLE;
                core_err_d = 1'b0;
            end
            default: begin
                state_d    = LSU_IDLE;
                mem_req_d  = 1'b0;
                core_err_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= LSU_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= 3'b000;
            off_q      <= 2'b00;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'b0000;
            mem_addr_q <= 32'h0000_0000;
            mem_wd_q   <= 32'h0000_0000;
            core_rd_q  <= 32'h0000_0000;
            core_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            off_q      <= off_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            core_rd_q  <= core_rd_d;
            core_err_q <= core_err_d;
        end
    end

    assign core_stall_o = core_req_i & (state_q != LSU_DONE);
    assign core_rd_o    = core_rd_q;
    assign core_err_o   = core_err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_be_o     = mem_be_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wd_o     = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// -----------------------------------------------------------------------------
// tb_riscv_lsu
// Directed plus randomized accesses against a byte-level reference model of
// the load/store rules; memory responder with programmable wait states.
// -----------------------------------------------------------------------------
module tb_riscv_lsu;
    import riscv_pkg::*;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'b000;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wd_i = 32'h0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_rd_i = 32'h0;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] rd_model = 32'h0;

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_err_o   (core_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rd_i     (mem_rd_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] s);
        if (s[1:0] == 2'd0) return 1;
        if (s[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit is_fault(input logic [2:0] s, input logic [31:0] a);
        bit legal;
        legal = (s == 3'b000) || (s == 3'b001) || (s == 3'b010) ||
                (s == 3'b100) || (s == 3'b101);
        return !legal || ((a % nbytes(s)) != 0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] s, input logic [31:0] a);
        int n;
        int off;
        n   = nbytes(s);
        off = int'(a % 4);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] s, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(s);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ext(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] rdata);
        longint v;
        longint mask;
        int n;
        n    = nbytes(s);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = longint'({32'h0, rdata} >> (8 * (a % 4))) & mask;
        if (!s[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One access; wait_n = BUSY cycles before mem_ready_i (>= TO never answers).
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int wait_n);
        bit f;
        bit exp_err;
        int exp_req;
        int stall_n;
        int req_n;
        bit done;
        f       = is_fault(size, addr);
        exp_err = f || (wait_n >= TO);
        exp_req = f ? 0 : ((wait_n < TO) ? wait_n + 1 : TO);
        stall_n = 0;
        req_n   = 0;
        done    = 0;
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            #1;
            if (core_stall_o) stall_n++;
            if (mem_req_o) begin
                chk("mem_we", {31'h0, mem_we_o}, {31'h0, we});
                chk("mem_be", {28'h0, mem_be_o}, {28'h0, exp_be(size, addr)});
                chk("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
                if (we) chk("mem_wd", mem_wd_o, exp_wd(size, wd));
                mem_ready_i = (req_n == wait_n);
                mem_rd_i    = (req_n == wait_n) ? rdata : $urandom;
                req_n++;
            end else if (!core_stall_o) begin
                done = 1;
                if (exp_err) rd_model = 32'h0;
                else if (!we) rd_model = exp_ext(size, addr, rdata);
                chk("core_err", {31'h0, core_err_o}, {31'h0, exp_err});
                chk("core_rd", core_rd_o, rd_model);
                chk("stall_cycles", stall_n, f ? 1 : 1 + exp_req);
                chk("req_cycles", req_n, exp_req);
            end else begin
                // Ready outside BUSY must be ignored.
                mem_ready_i = 1'($urandom_range(0, 1));
                mem_rd_i    = $urandom;
            end
            if (!done) @(negedge clk_i);
        end
        if (!done) begin
            n_assert++;
            n_fail++;
            $error("FAIL access_timeout: observed no DONE expected DONE within 100 cycles");
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk_i);
        core_req_i  = 1'b0;
        mem_ready_i = 1'($urandom_range(0, 1));
        repeat (n) @(negedge clk_i);
        #1;
        chk("idle_stall", {31'h0, core_stall_o}, 32'h0);
        chk("idle_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("idle_rd_hold", core_rd_o, rd_model);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, {31'h0, mem_req_o}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we_o}, 32'h0);
        chk({tag, "_mem_be"}, {28'h0, mem_be_o}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_mem_wd"}, mem_wd_o, 32'h0);
        chk({tag, "_core_rd"}, core_rd_o, 32'h0);
        chk({tag, "_core_err"}, {31'h0, core_err_o}, 32'h0);
    endtask

    initial begin
        logic       rwe;
        logic [2:0] rsz;
        logic [31:0] raddr;

        // Reset state
        #2;
        chk_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // LB 0x1003, ready in first BUSY cycle
        access(1'b0, LDST_B, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        chk("lb_value", core_rd_o, 32'hFFFF_FF80);
        idle(1);

        // LHU 0x2002, three wait cycles
        access(1'b0, LDST_HU, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 3);
        chk("lhu_value", core_rd_o, 32'h0000_BEEF);
        idle(1);

        // SB 0x3001, rd must hold previous load
        access(1'b1, LDST_B, 32'h0000_3001, 32'h0000_00A5, 32'h0, 1);
        chk("sb_rd_hold", core_rd_o, 32'h0000_BEEF);

        // Faults: misaligned LW, illegal size
        access(1'b0, LDST_W, 32'h0000_4002, 32'h0, 32'h1234_5678, 0);
        chk("lw_mis_rd", core_rd_o, 32'h0);
        access(1'b0, 3'b111, 32'h0000_4000, 32'h0, 32'h1234_5678, 0);
        idle(2);

        // Timeout and ready-on-last-cycle boundary
        access(1'b0, LDST_W, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 1000);
        access(1'b0, LDST_W, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, TO - 1);
        chk("lw_last_cycle", core_rd_o, 32'hCAFE_F00D);

        // Reset in the middle of BUSY
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = LDST_W;
        core_addr_i = 32'h0000_6000;
        mem_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("pre_reset_mem_req", {31'h0, mem_req_o}, 32'h1);
        core_req_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        chk_reset_outputs("midbusy");
        rd_model = 32'h0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        access(1'b1, LDST_W, 32'h0000_7000, 32'h1357_9BDF, 32'h0, 0);

        // Randomized accesses, sometimes back to back
        for (int i = 0; i < 60; i++) begin
            rwe   = 1'($urandom_range(0, 1));
            rsz   = 3'($urandom_range(0, 7));
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                raddr[1:0] = (rsz[1:0] == 2'd2) ? 2'b00 :
                             (rsz[1:0] == 2'd1) ? {raddr[1], 1'b0} : raddr[1:0];
            end
            access(rwe, rsz, raddr, $urandom, $urandom, int'($urandom_range(0, TO + 1)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit between the core datapath (initiator) and the data memory (responder).
- Accepts one core request at a time, stalling the core until the access completes.
- Converts the LDST_* access size plus address into a word-aligned memory request with byte enables and lane-replicated write data.
- Aligns and sign/zero-extends load data; flags misaligned, illegal-size and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 64, maximum BUSY cycles waiting for mem_ready_i before the access is abandoned (>=1)

Ports:
clk_i  in  1  single clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
core_req_i  in  1  core requests an access; held stable while core_stall_o=1
core_we_i  in  1  1=store, 0=load
core_size_i  in  3  LDST_B/H/W/BU/HU encoding
core_addr_i  in  32  byte address
core_wd_i  in  32  store data, right-aligned
core_rd_o  out  32  extended load data, valid in DONE cycle
core_stall_o  out  1  core must hold request and not advance
core_err_o  out  1  access fault pulse in DONE cycle
mem_req_o  out  1  memory request, high throughout BUSY
mem_we_o  out  1  memory write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word address {addr[31:2],2'b00}
mem_wd_o  out  32  lane-replicated write data
mem_ready_i  in  1  memory completes access this cycle
mem_rd_i  in  32  read word, valid when mem_ready_i=1

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0, core_rd_o=0, core_err_o=0, timeout counter=0.
- core_stall_o = core_req_i & (state!=DONE); combinational.
- IDLE: on core_req_i, register we/size/addr/wd.
  - Illegal size (011,110,111), H/HU with addr[0]=1, or W with addr[1:0]!=0 -> DONE with err=1, rd=0, no memory access.
  - Otherwise -> BUSY.
- BUSY: mem_req_o=1 with registered fields; counter increments each cycle.
  - mem_ready_i=1 -> DONE; on loads, latch extended mem_rd_i into core_rd_o.
  - Counter reaches TIMEOUT_CYCLES-1 without mem_ready_i -> DONE with err=1, rd=0, and mem_req_o drops.
  - mem_ready_i wins if both occur in the same cycle.
- DONE: stall=0 for exactly one cycle; core_err_o valid this cycle only; then -> IDLE. core_rd_o holds its value until the next load completes.
- Minimum latency: request cycle (IDLE) + 1 BUSY + DONE = 3 cycles; stall is high for 2 of them.
- Back-to-back: a request present in the cycle after DONE is a new access.
- Byte enables, where off=addr[1:0]:
  - B/BU: 0001<<off
  - H/HU: 0011<<off
  - W: 1111
- Write data:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- Load extension:
  - B: byte at off, sign-extended; BU: same byte, zero-extended.
  - H: halfword at addr[1], sign-extended; HU: same halfword, zero-extended.
  - W: word unchanged.
- Stores leave core_rd_o unchanged.
- Reset asserted mid-BUSY aborts the access immediately; no memory-side cleanup.
- mem_ready_i outside BUSY is ignored.

Decomposition:
- riscv_pkg keeps LDST_* constants.
- Add to riscv_pkg: typedef enum logic [1:0] lsu_state_t {LSU_IDLE, LSU_BUSY, LSU_DONE}.
- One combinational sub-module, riscv_lsu_align. Inputs: size, offset, wd, rd_word. Outputs: be, wd_rep, rd_ext, misalign/illegal. The FSM, counter and registers stay in riscv_lsu.

Test Plan:
- LB at 0x1003, memory returns 0x80FF_1234 with mem_ready_i in the first BUSY cycle -> mem_be_o=1000, addr 0x1000, core_rd_o=0xFFFF_FF80, stall high 2 cycles, err=0.
- LHU at 0x2002, rd_i=0xBEEF_0001 after 3 wait cycles -> be=1100, core_rd_o=0x0000_BEEF, stall high 5 cycles.
- SB wd=0x0000_00A5 at 0x3001 -> mem_we_o=1, be=0010, mem_wd_o=0xA5A5_A5A5, core_rd_o unchanged.
- LW at 0x4002 and size=3'b111 at 0x4000 -> no mem_req_o, err pulse in DONE, rd=0.
- LW with mem_ready_i never asserted, TIMEOUT_CYCLES=4 -> mem_req_o high exactly 4 cycles, then DONE with err=1.
- rst_ni low during BUSY -> all outputs return to reset values asynchronously; a new SW after reset completes normally with be=1111.
